// File: rtl/teamd_serial_pkg.sv
// Shared definitions for the TEAMD asynchronous serial transmitter and receiver.
//   DATA_W     : data bits per frame
//   tx_state_t : transmitter frame states
//   frame_len  : cycles per frame for a given bit period and parity setting
package teamd_serial_pkg;

  localparam int DATA_W = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // start + data + stop, plus one parity bit when enabled
  function automatic int frame_len(input int clks_per_bit, input bit parity);
    return clks_per_bit * (DATA_W + (parity ? 3 : 2));
  endfunction

endpackage

// File: rtl/teamd_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles and flags the last one.
//   CLK       : clock
//   Reset     : synchronous active-high reset
//   restart_i : clear the count (driven on every state change)
//   bit_end_o : high in the last cycle of the current bit period
module teamd_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic CLK,
  input  logic Reset,
  input  logic restart_i,
  output logic bit_end_o
);

  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_end_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || bit_end_o) cnt_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/teamd_async_serial_tx.sv
// Asynchronous serial transmitter: start bit, DATA_W data bits LSB first,
// optional even-parity bit, stop bit. Line idles high.
// Optional feature macro: TEAMD_TX_PARITY_EN (adds the parity bit).
//   CLK   : clock
//   Reset : synchronous active-high reset
//   Data  : word to send, captured on an accepted Load
//   Load  : load strobe, accepted only while Busy=0
//   Tx    : serial line (flop output)
//   Busy  : frame in progress
//   Done  : one-cycle pulse when a frame finishes
module teamd_async_serial_tx #(
  parameter int DATA_W       = teamd_serial_pkg::DATA_W,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [DATA_W-1:0] Data,
  input  logic              Load,
  output logic              Tx,
  output logic              Busy,
  output logic              Done
);

  import teamd_serial_pkg::*;

  localparam int            IW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;
  logic              accept;
  logic              last_bit;
`ifdef TEAMD_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  assign accept   = Load && !busy_q;
  assign last_bit = (idx_q == LAST_IDX);

  // Restarting on every state change keeps each state exactly one bit period long.
  teamd_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .CLK       (CLK),
    .Reset     (Reset),
    .restart_i (state_d != state_q),
    .bit_end_o (bit_end)
  );

  // state register
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = START;
      START: if (bit_end) state_d = DATA;
      DATA:
        if (bit_end && last_bit) begin
`ifdef TEAMD_TX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
`ifdef TEAMD_TX_PARITY_EN
      PARITY: if (bit_end) state_d = STOP;
`endif
      STOP:  if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath next values: shift register, bit index, parity
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (state_q == IDLE && accept) shift_d = Data;
    if (state_q == START) idx_d = '0;
    if (state_q == DATA && bit_end && !last_bit) begin
      shift_d = shift_q >> 1;
      idx_d   = idx_q + IW'(1);
    end
  end

`ifdef TEAMD_TX_PARITY_EN
  always_comb begin
    par_d = par_q;
    if (state_q == IDLE && accept) par_d = ^Data;
  end
`endif

  // Outputs are computed from the next state so the flops line up with it.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef TEAMD_TX_PARITY_EN
      PARITY: tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TEAMD_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef TEAMD_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign Tx   = tx_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_teamd_async_serial_tx.sv
// Directed bench for teamd_async_serial_tx: instance A uses CLKS_PER_BIT=1,
// instance B uses CLKS_PER_BIT=4. Expected frames are hand-written bit
// patterns, bit 0 = start bit, sent first. Honours TEAMD_TX_PARITY_EN.
module tb_teamd_async_serial_tx;

`ifdef TEAMD_TX_PARITY_EN
  localparam int NB = 10;
  localparam logic [9:0] E55 = 10'h2AA, E01 = 10'h302, E54 = 10'h3A8,
                         E7F = 10'h3FE, E00 = 10'h200, E2A = 10'h354;
`else
  localparam int NB = 9;
  localparam logic [9:0] E55 = 10'h1AA, E01 = 10'h102, E54 = 10'h1A8,
                         E7F = 10'h1FE, E00 = 10'h100, E2A = 10'h154;
`endif

  typedef struct {
    int         sel;
    logic [6:0] d;
    logic [9:0] bits;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstA, rstB, loadA, loadB;
  logic [6:0] dataA, dataB;
  logic       txA, busyA, doneA, txB, busyB, doneB;
  int         cur = 0;
  int         total = 0;
  int         bad = 0;
  logic       tx_s, busy_s, done_s;

  always #5 clk = ~clk;

  assign tx_s   = (cur == 0) ? txA   : txB;
  assign busy_s = (cur == 0) ? busyA : busyB;
  assign done_s = (cur == 0) ? doneA : doneB;

  teamd_async_serial_tx #(.DATA_W(7), .CLKS_PER_BIT(1)) dutA (
    .CLK(clk), .Reset(rstA), .Data(dataA), .Load(loadA),
    .Tx(txA), .Busy(busyA), .Done(doneA));

  teamd_async_serial_tx #(.DATA_W(7), .CLKS_PER_BIT(4)) dutB (
    .CLK(clk), .Reset(rstB), .Data(dataB), .Load(loadB),
    .Tx(txB), .Busy(busyB), .Done(doneB));

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0b want=%0b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input int s, input logic l, input logic [6:0] d);
    if (s == 0) begin loadA = l; dataA = d; end
    else        begin loadB = l; dataB = d; end
  endtask

  // Entered at the first negedge after the load was accepted; returns at the
  // negedge where Done must be high. inj >= 0 pulses a Load of 7'h00 mid-frame.
  task automatic check_frame(input logic [9:0] bits, input int inj);
    int cpb;
    cpb = (cur == 0) ? 1 : 4;
    for (int n = 0; n < NB * cpb; n++) begin
      chk("tx_bit", tx_s, bits[n / cpb]);
      chk("busy_hi", busy_s, 1'b1);
      chk("done_lo", done_s, 1'b0);
      if (n == inj)          drive(cur, 1'b1, 7'h00);
      else if (n == inj + 1) drive(cur, 1'b0, 7'h00);
      @(negedge clk);
    end
    chk("done_pulse", done_s, 1'b1);
    chk("busy_end", busy_s, 1'b0);
    chk("tx_idle", tx_s, 1'b1);
  endtask

  task automatic run_frame(input int s, input logic [6:0] d, input logic [9:0] bits);
    cur = s;
    drive(s, 1'b1, d);
    @(negedge clk);
    drive(s, 1'b0, ~d);   // Data moves after acceptance; frame must not care
    check_frame(bits, -1);
    @(negedge clk);
    chk("done_once", done_s, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[6];
    vt[0] = '{0, 7'h55, E55};
    vt[1] = '{1, 7'h01, E01};
    vt[2] = '{0, 7'h54, E54};
    vt[3] = '{0, 7'h7F, E7F};
    vt[4] = '{1, 7'h00, E00};
    vt[5] = '{0, 7'h2A, E2A};

    rstA = 1'b1; rstB = 1'b1;
    loadA = 1'b0; loadB = 1'b0;
    dataA = '0; dataB = '0;
    repeat (2) @(negedge clk);
    chk("rst_txA", txA, 1'b1);   chk("rst_busyA", busyA, 1'b0); chk("rst_doneA", doneA, 1'b0);
    chk("rst_txB", txB, 1'b1);   chk("rst_busyB", busyB, 1'b0); chk("rst_doneB", doneB, 1'b0);
    rstA = 1'b0; rstB = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_txA", txA, 1'b1); chk("idle_busyA", busyA, 1'b0); chk("idle_doneA", doneA, 1'b0);
      chk("idle_txB", txB, 1'b1); chk("idle_busyB", busyB, 1'b0); chk("idle_doneB", doneB, 1'b0);
    end

    foreach (vt[i]) run_frame(vt[i].sel, vt[i].d, vt[i].bits);

    // Load during a frame is ignored; Load in the Done cycle starts at once.
    cur = 0;
    drive(0, 1'b1, 7'h7F);
    @(negedge clk);
    drive(0, 1'b0, 7'h7F);
    check_frame(E7F, 3);
    drive(0, 1'b1, 7'h00);
    @(negedge clk);
    drive(0, 1'b0, 7'h55);
    check_frame(E00, -1);
    @(negedge clk);
    chk("b2b_done_once", done_s, 1'b0);

    // Reset during data bit 3 abandons the frame.
    drive(0, 1'b1, 7'h2A);
    @(negedge clk);
    drive(0, 1'b0, 7'h2A);
    for (int n = 0; n < 4; n++) begin
      chk("pre_rst_tx", txA, E2A[n]);
      @(negedge clk);
    end
    chk("bit3_tx", txA, E2A[4]);
    rstA = 1'b1;
    @(negedge clk);
    rstA = 1'b0;
    chk("mid_rst_tx", txA, 1'b1); chk("mid_rst_busy", busyA, 1'b0); chk("mid_rst_done", doneA, 1'b0);
    @(negedge clk);
    chk("post_rst_tx", txA, 1'b1); chk("post_rst_busy", busyA, 1'b0);

    // Reset together with Load: load dropped.
    rstA = 1'b1;
    drive(0, 1'b1, 7'h7F);
    @(negedge clk);
    rstA = 1'b0;
    drive(0, 1'b0, 7'h7F);
    chk("rl_busy", busyA, 1'b0); chk("rl_tx", txA, 1'b1);
    @(negedge clk);
    chk("rl_busy2", busyA, 1'b0); chk("rl_tx2", txA, 1'b1);

    run_frame(0, 7'h2A, E2A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/teamd_async_serial_tx.md
# teamd_async_serial_tx

Asynchronous serial transmitter for the TEAMD design; the transmit-side counterpart of the asynchronous serial interface receiver. It accepts a 7-bit parallel word on a single-cycle load strobe and serialises it on `Tx` as a start bit, 7 data bits LSB first, and a stop bit, with an optional parity bit. It sits beside the receiver at the top level, shares its clock, and can be looped `Tx`→`Rx` for self-test.

## Interface

Parameters:

- `DATA_W`, default 7: data bits per frame; matches the receiver's `iD0..iD6`.
- `CLKS_PER_BIT`, default 1: `CLK` cycles each bit is held on `Tx`. Must be ≥1. The default of 1 matches the receiver's one-sample-per-clock shifting.

Ports:

- `CLK`, input, 1: sole clock; all state updates on the rising edge.
- `Reset`, input, 1: reset, synchronous, active-high.
- `Data`, input, `DATA_W`: word to send; sampled only on an accepted load.
- `Load`, input, 1: load strobe; accepted only when `Busy`=0.
- `Tx`, output, 1: serial line; idles high.
- `Busy`, output, 1: frame in progress; high from the cycle after an accepted load until the stop bit completes.
- `Done`, output, 1: one-cycle pulse when a frame finishes.

## Operation

States:

- IDLE → START: on `Load` with `Busy`=0. `Data` is captured into the shift register in the same edge.
- START → DATA: after `CLKS_PER_BIT` cycles. `Tx`=0 throughout START.
- DATA: shifts out bit 0 first, then bits 1..6.
  - Each bit is held `CLKS_PER_BIT` cycles.
  - A 3-bit index counts 0..`DATA_W`-1.
  - After the last bit, goes to PARITY if enabled, otherwise STOP.
- PARITY: `Tx` = even-parity bit (XOR of the captured data), held `CLKS_PER_BIT` cycles, then STOP.
- STOP: `Tx`=1 for `CLKS_PER_BIT` cycles, then IDLE.

Outputs and control:

- `Done` pulses in the first IDLE cycle after STOP.
- `Busy`=1 in START, DATA, PARITY and STOP; 0 in IDLE.
- Bit-period counter width: `$clog2(CLKS_PER_BIT)` bits, minimum 1. It resets to 0 at every state change and wraps at `CLKS_PER_BIT`-1.
- `Tx` is registered and glitch-free; it is driven directly from a flop.

Boundary cases:

- `Load` while `Busy`=1: ignored. The frame in flight and the captured data are unchanged. No queueing.
- `Load` in the `Done` cycle: accepted, since `Busy`=0. This gives back-to-back frames with exactly one idle-high cycle between stop and the next start.
- `Reset` mid-frame: at the next edge `Tx`=1, state=IDLE, `Busy`=0, `Done`=0, counters cleared. The partial frame is abandoned.
- `Reset` and `Load` together: `Reset` wins; the load is dropped.
- `Data` changing after acceptance: no effect on the frame in flight.

## Timing

- Reset values: `Tx`=1, `Busy`=0, `Done`=0, state=IDLE.
- Load accepted at edge k:
  - `Tx` falls and `Busy` rises at edge k+1.
  - Data bit i appears at edge k+1+`CLKS_PER_BIT`·(1+i).
- Frame length: F = `CLKS_PER_BIT`·(`DATA_W`+2) cycles, or F = `CLKS_PER_BIT`·(`DATA_W`+3) with parity.
- `Done` is high for exactly one cycle, at edge k+1+F; `Busy` falls on the same edge.
- Minimum load-to-load spacing: F+1 cycles.

## Configuration

- Macro: `TEAMD_TX_PARITY_EN`.
- Defined: PARITY state present; even-parity bit inserted between the last data bit and stop. With default parameters, a frame is 10 cycles.
- Undefined: PARITY state and parity logic compiled out. With default parameters, a frame is 9 cycles and matches the current receiver's frame.

## Structure

- Shared package `teamd_serial_pkg`:
  - `DATA_W` constant.
  - State enum `tx_state_t` (IDLE, START, DATA, PARITY, STOP).
  - Function `frame_len(clks_per_bit, parity)`.
  - The receiver-side rework reuses the same package.
- Sub-module `teamd_bit_timer`:
  - Counts `CLKS_PER_BIT` cycles.
  - Outputs a `bit_end` tick.
  - Restart input driven on each state change.
- Top: state register, shift register, bit index, parity accumulator, output flops.

## Test plan

- Reset then idle 20 cycles → `Tx`=1, `Busy`=0, `Done`=0 throughout.
- Macro undefined, `CLKS_PER_BIT`=1, `Data`=7'h55, one-cycle `Load`:
  - `Tx` from the next cycle = 0,1,0,1,0,1,0,1,1.
  - `Busy` high for 9 cycles.
  - `Done` pulses on the 10th cycle.
- `CLKS_PER_BIT`=4, `Data`=7'h01 → start low for 4 cycles, then bit0=1 for 4 cycles, then 0 for 24 cycles, then stop high for 4 cycles. `Done` arrives 37 cycles after load.
- `Load` with 7'h7F, second `Load` with 7'h00 mid-frame, third `Load` with 7'h00 in the `Done` cycle:
  - Second load is ignored; first frame sends all ones.
  - Third load starts immediately; one idle-high cycle separates the two frames.
- `Reset` asserted at data bit 3 of 7'h2A → `Tx`=1, `Busy`=0 at the next edge. A subsequent load of 7'h2A sends a complete, correct frame.
- Macro defined, `Data`=7'h55 → parity bit 0 before stop. With `Data`=7'h54 → parity bit 1. Frame is 10 cycles in both cases.
